// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: state encoding, buffered
// fetch entry and small address helpers.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two synchronous FIFO of {pc, instr} entries whose
// head is held in dedicated registers so decode sees glitch-free outputs.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         head_valid,
  output fetch_entry_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           head_valid_r;
  fetch_entry_t   head_r;

  logic           full_s;
  logic           pop_ok_s;
  logic           push_ok_s;
  logic [AW-1:0]  rd_next_s;
  logic [CW-1:0]  next_count_s;
  fetch_entry_t   next_head_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & (count_r != '0);
  assign push_ok_s = push & (~full_s | pop_ok_s);
  assign rd_next_s = rd_ptr_r + AW'(1);

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    next_count_s = count_r;
    if (flush) begin
      next_count_s = '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   next_count_s = count_r + CW'(1);
        2'b01:   next_count_s = count_r - CW'(1);
        default: next_count_s = count_r;
      endcase
    end
  end

  // Next head: the entry behind the popped one, or a push landing in an empty slot.
  always_comb begin
    next_head_s = head_r;
    if (flush) begin
      next_head_s = head_r;
    end else if (pop_ok_s) begin
      if (count_r > CW'(1)) begin
        next_head_s = mem_r[rd_next_s];
      end else if (push_ok_s) begin
        next_head_s = push_entry;
      end else begin
        next_head_s = head_r;
      end
    end else if ((count_r == '0) && push_ok_s) begin
      next_head_s = push_entry;
    end else begin
      next_head_s = head_r;
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      head_valid_r <= 1'b0;
      head_r       <= '0;
    end else begin
      count_r      <= next_count_s;
      head_valid_r <= (next_count_s != '0);
      head_r       <= next_head_s;
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_ok_s) begin
          mem_r[wr_ptr_r] <= push_entry;
          wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
        if (pop_ok_s) begin
          rd_ptr_r <= rd_next_s;
        end
      end
    end
  end

  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head       = head_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, RUN/HALT/FAULT control, redirect and
// misaligned-target fault handling in front of the fetch buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            imem_req_o,
  input  logic [XLEN-1:0] imem_instr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o
);

  import fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_r;
  fetch_state_t    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic            fault_r;
  logic [XLEN-1:0] fault_pc_r;

  logic            misaligned_s;
  logic            flush_s;
  logic            pop_s;
  logic            room_s;
  logic            fetch_s;
  logic [CW-1:0]   fifo_count_s;
  logic            head_valid_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;

  assign misaligned_s = redirect_valid_i & is_misaligned(redirect_pc_i);
  // Once faulted, redirects are ignored entirely.
  assign flush_s      = redirect_valid_i & (state_r != FAULT);
  assign pop_s        = head_valid_s & instr_ready_i;
  assign room_s       = (fifo_count_s < CW'(FIFO_DEPTH)) | pop_s;
  assign fetch_s      = ~rst & (state_r == RUN) & ~halt_i & ~redirect_valid_i & room_s;

  assign push_entry_s.pc    = pc_r;
  assign push_entry_s.instr = imem_instr_i;

  // Control state transitions; a misaligned redirect outranks halt.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (misaligned_s) begin
          state_next_s = FAULT;
        end else if (halt_i) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT: begin
        if (misaligned_s) begin
          state_next_s = FAULT;
        end else if (~halt_i) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALT;
        end
      end
      FAULT:   state_next_s = FAULT;
      default: state_next_s = FAULT;
    endcase
  end

  // State, PC and sticky fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      fault_r    <= 1'b0;
      fault_pc_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (flush_s && !misaligned_s) begin
        pc_r <= redirect_pc_i;
      end else if (fetch_s) begin
        pc_r <= pc_r + XLEN'(4);
      end
      if (flush_s && misaligned_s) begin
        fault_r    <= 1'b1;
        fault_pc_r <= redirect_pc_i;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fetch_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .count      (fifo_count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign imem_addr_o   = pc_r;
  assign imem_req_o    = fetch_s;
  assign instr_valid_o = head_valid_s;
  assign instr_o       = head_s.instr;
  assign instr_pc_o    = head_s.pc;
  assign fault_o       = fault_r;
  assign fault_pc_o    = fault_pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, wrap-around instance and a
// randomized run scored against a queue-based reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, halt, rv;
  logic [31:0] rpc;

  logic [31:0] imem_addr, imem_instr, instr, instr_pc, fault_pc;
  logic        imem_req, instr_valid, fault;
  logic [31:0] w_addr, w_instr, w_ins, w_pc, w_fpc;
  logic        w_req, w_valid, w_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0150_0093;
      32'h0000_0004: return 32'h0FF0_0093;
      32'h0000_0010: return 32'h01FF_C293;
      default:       return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  always_comb imem_instr = rom(imem_addr);
  always_comb w_instr    = rom(w_addr);

  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_addr_o(imem_addr), .imem_req_o(imem_req),
    .imem_instr_i(imem_instr), .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .halt_i(halt), .instr_valid_o(instr_valid), .instr_o(instr),
    .instr_pc_o(instr_pc), .instr_ready_i(ready), .fault_o(fault),
    .fault_pc_o(fault_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_addr_o(w_addr), .imem_req_o(w_req),
    .imem_instr_i(w_instr), .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .halt_i(1'b0), .instr_valid_o(w_valid), .instr_o(w_ins),
    .instr_pc_o(w_pc), .instr_ready_i(1'b1), .fault_o(w_fault),
    .fault_pc_o(w_fpc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks values before any clock edge.
  task automatic do_reset();
    ready = 1'b0; halt = 1'b0; rv = 1'b0; rpc = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst_first;
    bit          rdy, hlt, rdv;
    logic [31:0] rtgt;
    bit          ev;
    logic [31:0] epc, ein;
    bit          ereq;
    logic [31:0] eaddr;
    bit          ef;
    logic [31:0] efpc;
  } vec_t;
  vec_t vt[$];

  task automatic v(input bit r, input bit rdy, input bit h, input bit rd, input logic [31:0] tg,
                   input bit ev, input logic [31:0] epc, input logic [31:0] ein,
                   input bit ereq, input logic [31:0] ea, input bit ef, input logic [31:0] efp);
    vec_t e;
    e.rst_first = r; e.rdy = rdy; e.hlt = h; e.rdv = rd; e.rtgt = tg;
    e.ev = ev; e.epc = epc; e.ein = ein; e.ereq = ereq; e.eaddr = ea;
    e.ef = ef; e.efpc = efp;
    vt.push_back(e);
  endtask

  // Reference model: a plain queue of {pc, instr} plus mode/pc/fault variables.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  int          mmode;   // 0 run, 1 halt, 2 fault
  logic [31:0] mpc, mfpc;
  bit          mfault;

  task automatic model_step();
    bit mpop, mfetch;
    ent_t e;
    mpop   = (mq.size() > 0) && ready;
    mfetch = (mmode == 0) && !halt && !rv && ((mq.size() < 2) || mpop);
    chk("rnd_valid", {31'h0, instr_valid}, {31'h0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("rnd_pc", instr_pc, mq[0].pc);
      chk("rnd_instr", instr, mq[0].ins);
    end
    chk("rnd_req", {31'h0, imem_req}, {31'h0, mfetch});
    chk("rnd_addr", imem_addr, mpc);
    chk("rnd_fault", {31'h0, fault}, {31'h0, mfault});
    chk("rnd_fault_pc", fault_pc, mfpc);
    if (mmode != 2 && rv) begin
      mq.delete();
      if (rpc[1:0] != 2'b00) begin
        mfault = 1'b1; mfpc = rpc; mmode = 2;
      end else begin
        mpc = rpc; mmode = halt ? 1 : 0;
      end
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mfetch) begin
        e.pc = mpc; e.ins = rom(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
      if (mmode != 2) mmode = halt ? 1 : 0;
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; halt = 1'b0; rv = 1'b0; rpc = 32'h0;

    // A: reset release, ready held high
    v(1,1,0,0,0, 0,0,0,                    1,32'h0, 0,0);
    v(0,1,0,0,0, 1,32'h0,32'h0150_0093,    1,32'h4, 0,0);
    v(0,1,0,0,0, 1,32'h4,32'h0FF0_0093,    1,32'h8, 0,0);
    v(0,1,0,0,0, 1,32'h8,rom(32'h8),       1,32'hC, 0,0);
    // C: ready low for 5 cycles, then drains with no gap
    v(1,0,0,0,0, 0,0,0,                    1,32'h0, 0,0);
    v(0,0,0,0,0, 1,32'h0,32'h0150_0093,    1,32'h4, 0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,0,0, 1,32'h0,32'h0150_0093, 0,32'h8, 0,0);
    v(0,1,0,0,0, 1,32'h0,32'h0150_0093,    1,32'h8, 0,0);
    v(0,1,0,0,0, 1,32'h4,32'h0FF0_0093,    1,32'hC, 0,0);
    v(0,1,0,0,0, 1,32'h8,rom(32'h8),       1,32'h10, 0,0);
    // B: redirect to 0x10 while full
    v(1,0,0,0,0, 0,0,0,                    1,32'h0, 0,0);
    v(0,0,0,0,0, 1,32'h0,32'h0150_0093,    1,32'h4, 0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,0,0, 1,32'h0,32'h0150_0093, 0,32'h8, 0,0);
    v(0,0,0,1,32'h10, 1,32'h0,32'h0150_0093, 0,32'h8, 0,0);
    v(0,1,0,0,0, 0,0,0,                    1,32'h10, 0,0);
    v(0,1,0,0,0, 1,32'h10,32'h01FF_C293,   1,32'h14, 0,0);
    v(0,1,0,0,0, 1,32'h14,rom(32'h14),     1,32'h18, 0,0);
    // D: halt for 4 cycles drains, then resumes at pc 8
    v(1,0,0,0,0, 0,0,0,                    1,32'h0, 0,0);
    v(0,0,0,0,0, 1,32'h0,32'h0150_0093,    1,32'h4, 0,0);
    v(0,1,1,0,0, 1,32'h0,32'h0150_0093,    0,32'h8, 0,0);
    v(0,1,1,0,0, 1,32'h4,32'h0FF0_0093,    0,32'h8, 0,0);
    v(0,1,1,0,0, 0,0,0,                    0,32'h8, 0,0);
    v(0,1,1,0,0, 0,0,0,                    0,32'h8, 0,0);
    v(0,1,0,0,0, 0,0,0,                    0,32'h8, 0,0);
    v(0,1,0,0,0, 0,0,0,                    1,32'h8, 0,0);
    v(0,1,0,0,0, 1,32'h8,rom(32'h8),       1,32'hC, 0,0);
    // E: misaligned redirect is terminal; later redirect ignored
    v(1,1,0,0,0, 0,0,0,                    1,32'h0, 0,0);
    v(0,1,0,1,32'h6, 1,32'h0,32'h0150_0093, 0,32'h4, 0,0);
    v(0,1,0,0,0, 0,0,0,                    0,32'h4, 1,32'h6);
    v(0,1,0,1,32'h10, 0,0,0,               0,32'h4, 1,32'h6);
    v(0,1,0,0,0, 0,0,0,                    0,32'h4, 1,32'h6);
    v(0,1,0,0,0, 0,0,0,                    0,32'h4, 1,32'h6);

    @(negedge clk);
    foreach (vt[i]) begin
      if (vt[i].rst_first) do_reset();
      ready = vt[i].rdy; halt = vt[i].hlt; rv = vt[i].rdv; rpc = vt[i].rtgt;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vt[i].ev});
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_pc", i), instr_pc, vt[i].epc);
        chk($sformatf("vec%0d_instr", i), instr, vt[i].ein);
      end
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].ereq});
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].eaddr);
      chk($sformatf("vec%0d_fault", i), {31'h0, fault}, {31'h0, vt[i].ef});
      chk($sformatf("vec%0d_fault_pc", i), fault_pc, vt[i].efpc);
      @(posedge clk);
      @(negedge clk);
    end

    // Wrap-around instance: FFFF_FFF8, FFFF_FFFC, 0000_0000
    do_reset();
    ready = 1'b1;
    #1 chk("wrap_req0", {31'h0, w_req}, 32'h1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("wrap_valid%0d", k), {31'h0, w_valid}, 32'h1);
      chk($sformatf("wrap_pc%0d", k), w_pc, exp_pc);
      chk($sformatf("wrap_instr%0d", k), w_ins, rom(exp_pc));
      chk($sformatf("wrap_fault%0d", k), {31'h0, w_fault}, 32'h0);
    end
    @(negedge clk);

    // Randomized run against the reference model
    do_reset();
    mq.delete(); mmode = 0; mpc = 32'h0; mfault = 1'b0; mfpc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      rv = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00})
                                        : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if (c == 2990) begin
        rv = 1'b1; rpc = 32'h0000_0102;
      end
      #1;
      model_step();
      @(posedge clk);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit and initiator side of the instruction ROM interface. Holds the PC and drives a word address to the combinational instruction memory every cycle. Captures the returned word plus its PC into a small FIFO, and presents them to decode with a valid/ready handshake. Handles redirects from branches/jumps, halt requests, and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
FIFO_DEPTH, 2, fetch buffer entries (power of two, >= 2).
XLEN, 32, address/instruction width.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr_o  out  XLEN  fetch address to instruction memory (always equals current PC).
imem_req_o  out  1  high in cycles where imem_instr_i is captured.
imem_instr_i  in  XLEN  instruction word; combinational, valid in the same cycle as imem_addr_o.
redirect_valid_i  in  1  one-cycle pulse: replace PC, flush buffer.
redirect_pc_i  in  XLEN  redirect target.
halt_i  in  1  level: stop new fetches while high.
instr_valid_o  out  1  FIFO head valid.
instr_o  out  XLEN  FIFO head instruction.
instr_pc_o  out  XLEN  PC of instr_o.
instr_ready_i  in  1  decode accepts head when instr_valid_o & instr_ready_i.
fault_o  out  1  sticky misaligned-redirect fault.
fault_pc_o  out  XLEN  offending target.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state RUN, instr_valid_o=0, instr_o=0, instr_pc_o=0, fault_o=0, fault_pc_o=0, imem_req_o=0 while rst high.
- States: RUN (fetching), HALT (no fetch, buffer drains), FAULT (no fetch, terminal until rst).
  - RUN->HALT: halt_i=1. HALT->RUN: halt_i=0.
  - Any->FAULT: redirect_valid_i=1 with redirect_pc_i[1:0]!=0. FAULT has priority over halt. In FAULT, redirect/halt are ignored.
- pop = instr_valid_o & instr_ready_i.
- fetch = (state==RUN) & ~halt_i & ~redirect_valid_i & ((count<FIFO_DEPTH) | pop). imem_req_o = fetch.
- On fetch: push {pc, imem_instr_i}; pc <= pc+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0, no fault).
- Latency: the first instruction after reset release appears on instr_valid_o one cycle later (registered FIFO head). Steady-state throughput is 1 instr/cycle with ready held high.
- Simultaneous push and pop when full is allowed; count is unchanged.
- Redirect (aligned):
  - A pop of the current head in that cycle completes normally.
  - FIFO is flushed (count<=0), no push, pc<=redirect_pc_i.
  - Next cycle: instr_valid_o=0 and fetch resumes from the target; target instruction is valid the cycle after.
  - A redirect in HALT updates pc and flushes; state stays HALT.
- Misaligned redirect: flush, pc unchanged, fault_o<=1, fault_pc_o<=redirect_pc_i. instr_valid_o=0 thereafter.
- Stall: instr_o/instr_pc_o hold stable while instr_valid_o & ~instr_ready_i.
- Reset mid-operation: immediate return to reset values, FIFO contents discarded.

Decomposition:
- Package fetch_pkg:
  - XLEN
  - NOP_INSTR=32'h0000_0013
  - fetch_state_t enum {RUN, HALT, FAULT}
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty, and registered head outputs.
- PC, state machine and fault logic stay in instr_fetch.

Test Plan:
- Reset release with ROM attached, ready=1 -> cycle1: instr_valid_o=1, instr_pc_o=0, instr_o=32'h0150_0093; cycle2: pc 4, 32'h0FF0_0093; then consecutive +4 PCs.
- ready=0 for 5 cycles after reset -> exactly 2 entries buffered, imem_req_o=0 after 2 fetches, head holds pc 0; ready=1 -> pcs 0,4,8 delivered with no gap or duplicate.
- redirect to 32'h10 while FIFO full -> next cycle instr_valid_o=0; following cycle instr_pc_o=32'h10, instr_o=32'h01FF_C293.
- redirect to 32'h6 -> fault_o=1, fault_pc_o=32'h6, instr_valid_o stays 0 and imem_req_o=0 until rst.
- halt_i=1 for 4 cycles with ready=1 -> buffered entries drain, then valid=0; halt_i=0 -> fetch resumes from the next sequential PC with no skipped address.
- RESET_PC=32'hFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 with no fault.
